// File: rtl/oit_display_scanner_if.sv
// Display scanner bus: value/decimal-point sources in, display pins out.
// master = value source (drives in/dp_in/enable), slave = scanner.
interface oit_display_scanner_if #(
  parameter int unsigned COUNT = 4
) ();
  logic                 enable;
  logic [COUNT*4-1:0]   in;
  logic [COUNT-1:0]     dp_in;
  logic [6:0]           seg;
  logic                 dp;
  logic [COUNT-1:0]     digit;
  logic                 frame;

  modport master (
    output enable, in, dp_in,
    input  seg, dp, digit, frame
  );

  modport slave (
    input  enable, in, dp_in,
    output seg, dp, digit, frame
  );
endinterface

// File: rtl/oit_display_scanner.sv
// Time-multiplexed multi-digit 7-segment scanner with a shared hex decoder,
// per-digit anti-ghosting blank interval and frame-aligned shadow capture.
// Optional macro OIT_SCAN_LZS_EN enables leading-zero suppression.
// Outputs are registered from the next-state values so they line up with
// the scan state while having no combinational path from the bus inputs.
module oit_display_scanner #(
  parameter int unsigned COUNT  = 4,
  parameter int unsigned DWELL  = 1000,
  parameter int unsigned BLANK  = 16,
  parameter int unsigned ACTIVE = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  oit_display_scanner_if.slave  bus
);

  localparam int unsigned TMAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int unsigned TW   = $clog2(TMAX + 1);
  localparam int unsigned IW   = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam int unsigned DW   = COUNT * 4;

  localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL - 1);
  localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK == 0) ? 0 : BLANK - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(COUNT - 1);
  localparam logic          INV        = (ACTIVE == 0);

  typedef enum logic {S_BLANK, S_ON} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q, index_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic [DW-1:0]   shadow_q, shadow_d;
  logic [COUNT-1:0] dps_q, dps_d;

  logic [6:0]       seg_q, seg_n;
  logic             dp_q, dp_n;
  logic [COUNT-1:0] digit_q, digit_n;
  logic             frame_q, frame_n;
  logic             capture;
  logic [3:0]       nibble;

  // Hex to active-high segments {a,b,c,d,e,f,g}.
  function automatic logic [6:0] decode(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'h7E; 4'h1: s = 7'h30; 4'h2: s = 7'h6D; 4'h3: s = 7'h79;
      4'h4: s = 7'h33; 4'h5: s = 7'h5B; 4'h6: s = 7'h5F; 4'h7: s = 7'h70;
      4'h8: s = 7'h7F; 4'h9: s = 7'h7B; 4'hA: s = 7'h77; 4'hB: s = 7'h1F;
      4'hC: s = 7'h4E; 4'hD: s = 7'h3D; 4'hE: s = 7'h4F; default: s = 7'h47;
    endcase
    return s;
  endfunction

`ifdef OIT_SCAN_LZS_EN
  // True when idx > 0 and every digit from idx upward is zero.
  function automatic logic lz_blank(input logic [DW-1:0] v, input logic [IW-1:0] idx);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < int'(COUNT); j++) begin
      if (j >= int'(idx)) nz = nz | (|v[j*4 +: 4]);
    end
    return (idx != '0) && !nz;
  endfunction
`endif

  // Next-state scan sequencing, shadow capture and output pattern.
  always_comb begin
    state_d  = state_q;
    index_d  = index_q;
    timer_d  = timer_q;
    shadow_d = shadow_q;
    dps_d    = dps_q;
    seg_n    = '0;
    dp_n     = 1'b0;
    digit_n  = '0;
    frame_n  = 1'b0;
    nibble   = '0;
    capture  = (index_q == '0) && (timer_q == '0) && ((state_q == S_BLANK) || (BLANK == 0));

    if (bus.enable) begin
      if (capture) begin
        shadow_d = bus.in;
        dps_d    = bus.dp_in;
      end
      case (state_q)
        S_BLANK: begin
          if ((BLANK == 0) || (timer_q == BLANK_LAST)) begin
            state_d = S_ON;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
        default: begin
          if (timer_q == DWELL_LAST) begin
            timer_d = '0;
            index_d = (index_q == IDX_LAST) ? '0 : index_q + IW'(1);
            frame_n = (index_q == IDX_LAST);
            state_d = (BLANK == 0) ? S_ON : S_BLANK;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      endcase

      if (state_d == S_ON) begin
        nibble           = shadow_d[{index_d, 2'b00} +: 4];
        digit_n[index_d] = 1'b1;
        dp_n             = dps_d[index_d];
        seg_n            = decode(nibble);
`ifdef OIT_SCAN_LZS_EN
        if (lz_blank(shadow_d, index_d)) seg_n = '0;
`endif
      end
    end
  end

  // State, shadow and polarity-adjusted output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_BLANK;
      index_q  <= '0;
      timer_q  <= '0;
      shadow_q <= '0;
      dps_q    <= '0;
      seg_q    <= {7{INV}};
      dp_q     <= INV;
      digit_q  <= {COUNT{INV}};
      frame_q  <= INV;
    end else begin
      state_q  <= state_d;
      index_q  <= index_d;
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      dps_q    <= dps_d;
      seg_q    <= seg_n ^ {7{INV}};
      dp_q     <= dp_n ^ INV;
      digit_q  <= digit_n ^ {COUNT{INV}};
      frame_q  <= frame_n ^ INV;
    end
  end

  assign bus.seg   = seg_q;
  assign bus.dp    = dp_q;
  assign bus.digit = digit_q;
  assign bus.frame = frame_q;

endmodule
